// File: rtl/pkt_order_fifo_if.sv
// Bus bundle for pkt_order_fifo: write/read handshakes, control strobes and status.
// The master drives push/pop/flush/err_clr and the FIFO (slave) returns data and flags.
interface pkt_order_fifo_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              flush;
    logic              w_enable;
    logic [DATA_W-1:0] w_data;
    logic              r_enable;
    logic [DATA_W-1:0] r_data;
    logic              err_clr;
    logic              empty;
    logic              full;
    logic              almost_full;
    logic              almost_empty;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic              underflow;

    modport master (
        output flush, w_enable, w_data, r_enable, err_clr,
        input  r_data, empty, full, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  flush, w_enable, w_data, r_enable, err_clr,
        output r_data, empty, full, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/pkt_order_fifo.sv
// Show-ahead packet-order FIFO with any DEPTH >= 2, threshold flags and sticky error flags.
// Memory is deliberately left out of reset; r_data is forced to zero whenever the FIFO is empty.
module pkt_order_fifo #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1
) (
    input  logic               clk,
    input  logic               rst,
    pkt_order_fifo_if.slave    bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              rd_ok, wr_ok;

    // Explicit compare-and-wrap so non-power-of-two depths never index past the array.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        rd_ok       = bus.r_enable && (count_q != '0);
        wr_ok       = bus.w_enable && ((count_q != FULL_CNT) || rd_ok);
        mem_d       = mem_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q && !bus.err_clr;
        underflow_d = underflow_q && !bus.err_clr;
        if (bus.flush) begin
            // Flush swallows any push/pop this cycle, so nothing counts as dropped.
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (wr_ok) begin
                mem_d[wptr_q] = bus.w_data;
                wptr_d        = ptr_inc(wptr_q);
            end
            if (rd_ok) begin
                rptr_d = ptr_inc(rptr_q);
            end
            if (wr_ok && !rd_ok) begin
                count_d = count_q + CNT_W'(1);
            end else if (rd_ok && !wr_ok) begin
                count_d = count_q - CNT_W'(1);
            end
            if (bus.w_enable && !wr_ok) begin
                overflow_d = 1'b1;
            end
            if (bus.r_enable && !rd_ok) begin
                underflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.r_data       = (count_q == '0) ? '0 : mem_q[rptr_q];
    assign bus.empty        = (count_q == '0);
    assign bus.full         = (count_q == FULL_CNT);
    assign bus.almost_full  = (count_q >= CNT_W'(AF_LEVEL));
    assign bus.almost_empty = (count_q <= CNT_W'(AE_LEVEL));
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule
